// File: rtl/byte_serial_add_ctrl_pkg.sv
// rtl/byte_serial_add_ctrl_pkg.sv - shared state encodings, byte width and counter sizing for the byte-serial adder
package byte_serial_add_ctrl_pkg;

  // Width of the shared adder datapath
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } bsa_state_t;

  // Byte counter width: clog2(nbytes), never narrower than one bit
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/byte_serial_add_ctrl_s8_bit_adder.sv
// rtl/byte_serial_add_ctrl_s8_bit_adder.sv - 8-bit ripple-carry adder shared by the byte-serial sequencer
module s8_bit_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Ripple the carry bit by bit through eight full adders
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// rtl/byte_serial_add_ctrl.sv - wide add sequencer over one 8-bit adder, LSB byte first; BSA_SUBTRACT_EN adds the sub port
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
`ifdef BSA_SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  carry_out
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  bsa_state_t    state;
  logic [CW-1:0] cnt;
  logic          carry_q;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  sum_sh;
  logic [W-1:0]  sum_shift;
  logic [7:0]    add_b;
  logic [7:0]    add_s;
  logic          add_c;
  logic          invert_b;
  logic          start_cin;

`ifdef BSA_SUBTRACT_EN
  logic sub_q;
  assign invert_b  = sub_q;
  assign start_cin = sub;
`else
  assign invert_b  = 1'b0;
  assign start_cin = 1'b0;
`endif

  // Subtraction feeds the inverted B byte; the +1 comes from the initial carry
  assign add_b = b_sh[7:0] ^ {8{invert_b}};

  s8_bit_adder u_adder (
    .a    (a_sh[7:0]),
    .b    (add_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_c)
  );

  // New result byte enters at the top so the LSB byte ends at [7:0] after NBYTES steps
  assign sum_shift = (sum_sh >> BYTE_W) | (W'(add_s) << (W - BYTE_W));

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      carry_q   <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BSA_SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= start_cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
`ifdef BSA_SUBTRACT_EN
            sub_q   <= sub;
`endif
          end
        end
        S_RUN: begin
          sum_sh  <= sum_shift;
          carry_q <= add_c;
          a_sh    <= a_sh >> BYTE_W;
          b_sh    <= b_sh >> BYTE_W;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            sum       <= sum_shift;
            carry_out <= add_c;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// tb/tb_byte_serial_add_ctrl.sv - scoreboard bench for byte_serial_add_ctrl with NBYTES=4
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_vec;
  int n_bad;
  logic [W:0] sb[$];
  logic [W:0] last_res;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef BSA_SUBTRACT_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
  endfunction

  // Every done pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("result", {carry_out, sum}, e);
        last_res = e;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub);
    bit seen;
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    sb.push_back(model(op_a, op_b, op_sub));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        check("latency", k, NB);
        check("busy_in_done", busy, 1);
      end else begin
        check("busy_in_run", busy, 1);
        check("sum_hold", {carry_out, sum}, last_res);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    check("busy_drop", busy, 0);
    check("done_pulse", done, 0);
  endtask

  initial begin
    bit seen;
    n_vec = 0; n_bad = 0; last_res = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h12345678, 32'h11111111, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op(32'h00FF00FF, 32'h00010001, 1'b0);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'b0);

    // Start while busy is ignored: monitor flags any extra done
    a = 32'h0BADF00D; b = 32'h01010101; start = 1'b1;
    sb.push_back(model(32'h0BADF00D, 32'h01010101, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 32'hAAAAAAAA; b = 32'hAAAAAAAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (NB + 6) @(posedge clk);
    #1;
    check("ignored_start_sum", {carry_out, sum}, model(32'h0BADF00D, 32'h01010101, 1'b0));
    check("ignored_start_idle", busy, 0);

    // Asynchronous reset during the second RUN cycle
    a = 32'h01020304; b = 32'h05060708; start = 1'b1;
    sb.push_back(model(32'h01020304, 32'h05060708, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", carry_out, 0);
    void'(sb.pop_back());
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'h89ABCDEF, 32'h76543211, 1'b0);

    // Back-to-back: start raised during DONE, held into the following IDLE cycle
    a = 32'h00000010; b = 32'h00000020; start = 1'b1;
    sb.push_back(model(32'h00000010, 32'h00000020, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) check("b2b_first_timeout", 0, 1);
    a = 32'hDEADBEEF; b = 32'h11111111; start = 1'b1;
    sb.push_back(model(32'hDEADBEEF, 32'h11111111, 1'b0));
    @(posedge clk); #1;
    check("b2b_done_ignores", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_idle_accepts", busy, 1);
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        check("b2b_latency", k, NB);
      end else begin
        check("b2b_sum_hold", {carry_out, sum}, model(32'h00000010, 32'h00000020, 1'b0));
      end
    end
    if (!seen) check("b2b_second_timeout", 0, 1);
    @(posedge clk); #1;

`ifdef BSA_SUBTRACT_EN
    run_op(32'h00000005, 32'h00000007, 1'b1);
    check("sub_neg", {carry_out, sum}, {1'b0, 32'hFFFFFFFE});
    run_op(32'h00000010, 32'h00000010, 1'b1);
    check("sub_zero", {carry_out, sum}, {1'b1, 32'h00000000});
    run_op(32'h12345678, 32'h11111111, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
